// File: rtl/writeback_queue.sv
// Per-pipe writeback FIFOs between the exec ports and the register controller.
// Same-address heads pop A first and hold B, so B's write lands last.
module writeback_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ALMOST = 1
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        enableA_i,
   input  logic        wbA_i,
   input  logic [4:0]  wbAddrA_i,
   input  logic [15:0] wbValA_i,
   input  logic [1:0]  operationStatusA_i,
   input  logic        enableB_i,
   input  logic        wbB_i,
   input  logic [4:0]  wbAddrB_i,
   input  logic [15:0] wbValB_i,
   input  logic [1:0]  operationStatusB_i,
   output logic        wbA_o,
   output logic [4:0]  wbAddrA_o,
   output logic [15:0] wbValA_o,
   output logic [1:0]  operationStatusA_o,
   output logic        wbB_o,
   output logic [4:0]  wbAddrB_o,
   output logic [15:0] wbValB_o,
   output logic [1:0]  operationStatusB_o,
   output logic        fullA_o,
   output logic        fullB_o,
   output logic        overflowA_o,
   output logic        overflowB_o,
   output logic        idle_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = 5 + 16 + 2;

   // Entry layout: {addr[22:18], value[17:2], status[1:0]}
   logic [EW-1:0] memA [DEPTH];
   logic [EW-1:0] memB [DEPTH];

   logic [PW-1:0] headA, tailA, headB, tailB;
   logic [CW-1:0] countA, countB;
   logic [CW-1:0] nextCountA, nextCountB;
   logic [EW-1:0] headEntA, headEntB;

   logic pushReqA, pushReqB;
   logic pushA, pushB;
   logic popA, popB;
   logic dropA, dropB;
   logic collide;
   logic fullNextA, fullNextB;
   logic idleNext;

   assign headEntA = memA[headA];
   assign headEntB = memB[headB];
   assign pushReqA = enableA_i && wbA_i;
   assign pushReqB = enableB_i && wbB_i;

   always_comb begin
      collide = (countA != '0) && (countB != '0) &&
                (headEntA[22:18] == headEntB[22:18]);
      popA = (countA != '0);
      popB = (countB != '0) && !collide;
      // A full FIFO still accepts a push when its head leaves in the same cycle.
      pushA = pushReqA && ((countA != CW'(DEPTH)) || popA);
      pushB = pushReqB && ((countB != CW'(DEPTH)) || popB);
      dropA = pushReqA && !pushA;
      dropB = pushReqB && !pushB;
      nextCountA = countA + CW'(pushA) - CW'(popA);
      nextCountB = countB + CW'(pushB) - CW'(popB);
      fullNextA = (DEPTH - 32'(nextCountA)) <= ALMOST;
      fullNextB = (DEPTH - 32'(nextCountB)) <= ALMOST;
      idleNext = (nextCountA == '0) && (nextCountB == '0) && !popA && !popB;
   end

   always_ff @(posedge clock_i) begin
      if (pushA) memA[tailA] <= {wbAddrA_i, wbValA_i, operationStatusA_i};
      if (pushB) memB[tailB] <= {wbAddrB_i, wbValB_i, operationStatusB_i};
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         headA  <= '0;
         tailA  <= '0;
         countA <= '0;
         headB  <= '0;
         tailB  <= '0;
         countB <= '0;
      end else begin
         if (pushA) tailA <= tailA + PW'(1);
         if (popA)  headA <= headA + PW'(1);
         if (pushB) tailB <= tailB + PW'(1);
         if (popB)  headB <= headB + PW'(1);
         countA <= nextCountA;
         countB <= nextCountB;
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         wbA_o              <= 1'b0;
         wbAddrA_o          <= '0;
         wbValA_o           <= '0;
         operationStatusA_o <= '0;
         wbB_o              <= 1'b0;
         wbAddrB_o          <= '0;
         wbValB_o           <= '0;
         operationStatusB_o <= '0;
         fullA_o            <= 1'b0;
         fullB_o            <= 1'b0;
         overflowA_o        <= 1'b0;
         overflowB_o        <= 1'b0;
         idle_o             <= 1'b0;
      end else begin
         wbA_o <= popA;
         wbB_o <= popB;
         if (popA) begin
            wbAddrA_o          <= headEntA[22:18];
            wbValA_o           <= headEntA[17:2];
            operationStatusA_o <= headEntA[1:0];
         end
         if (popB) begin
            wbAddrB_o          <= headEntB[22:18];
            wbValB_o           <= headEntB[17:2];
            operationStatusB_o <= headEntB[1:0];
         end
         fullA_o <= fullNextA;
         fullB_o <= fullNextB;
         if (dropA) overflowA_o <= 1'b1;
         if (dropB) overflowB_o <= 1'b1;
         idle_o <= idleNext;
      end
   end

endmodule

// File: tb/tb_writeback_queue.sv
// Scenario bench for writeback_queue: expected writebacks are queued at drive
// time and matched against DUT strobes by a negedge monitor.
module tb_writeback_queue;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        enableA_i = 1'b0, wbA_i = 1'b0;
   logic [4:0]  wbAddrA_i = '0;
   logic [15:0] wbValA_i = '0;
   logic [1:0]  operationStatusA_i = '0;
   logic        enableB_i = 1'b0, wbB_i = 1'b0;
   logic [4:0]  wbAddrB_i = '0;
   logic [15:0] wbValB_i = '0;
   logic [1:0]  operationStatusB_i = '0;
   logic        wbA_o, wbB_o;
   logic [4:0]  wbAddrA_o, wbAddrB_o;
   logic [15:0] wbValA_o, wbValB_o;
   logic [1:0]  operationStatusA_o, operationStatusB_o;
   logic        fullA_o, fullB_o, overflowA_o, overflowB_o, idle_o;

   int checks = 0;
   int failures = 0;
   logic [22:0] expA[$];
   logic [22:0] expB[$];
   logic [15:0] regs [32];

   writeback_queue #(.DEPTH(4), .ALMOST(1)) dut (
      .clock_i(clock_i), .reset_i(reset_i),
      .enableA_i(enableA_i), .wbA_i(wbA_i), .wbAddrA_i(wbAddrA_i),
      .wbValA_i(wbValA_i), .operationStatusA_i(operationStatusA_i),
      .enableB_i(enableB_i), .wbB_i(wbB_i), .wbAddrB_i(wbAddrB_i),
      .wbValB_i(wbValB_i), .operationStatusB_i(operationStatusB_i),
      .wbA_o(wbA_o), .wbAddrA_o(wbAddrA_o), .wbValA_o(wbValA_o),
      .operationStatusA_o(operationStatusA_o),
      .wbB_o(wbB_o), .wbAddrB_o(wbAddrB_o), .wbValB_o(wbValB_o),
      .operationStatusB_o(operationStatusB_o),
      .fullA_o(fullA_o), .fullB_o(fullB_o),
      .overflowA_o(overflowA_o), .overflowB_o(overflowB_o), .idle_o(idle_o)
   );

   always #5 clock_i = ~clock_i;

   // Scoreboard monitor; A is applied to the register model before B.
   always @(negedge clock_i) begin
      if (reset_i) begin
         if (wbA_o) begin
            checks++;
            if (expA.size() == 0) begin
               failures++;
               $display("FAIL wbA_unexpected got=%h want=none", {wbAddrA_o, wbValA_o, operationStatusA_o});
            end else begin
               logic [22:0] e;
               e = expA.pop_front();
               if ({wbAddrA_o, wbValA_o, operationStatusA_o} !== e) begin
                  failures++;
                  $display("FAIL wbA_entry got=%h want=%h", {wbAddrA_o, wbValA_o, operationStatusA_o}, e);
               end
            end
            regs[wbAddrA_o] = wbValA_o;
         end
         if (wbB_o) begin
            checks++;
            if (expB.size() == 0) begin
               failures++;
               $display("FAIL wbB_unexpected got=%h want=none", {wbAddrB_o, wbValB_o, operationStatusB_o});
            end else begin
               logic [22:0] e;
               e = expB.pop_front();
               if ({wbAddrB_o, wbValB_o, operationStatusB_o} !== e) begin
                  failures++;
                  $display("FAIL wbB_entry got=%h want=%h", {wbAddrB_o, wbValB_o, operationStatusB_o}, e);
               end
            end
            regs[wbAddrB_o] = wbValB_o;
         end
      end
   end

   task automatic driveA(input logic en, input logic wb, input logic [4:0] a,
                         input logic [15:0] v, input logic [1:0] s);
      enableA_i = en; wbA_i = wb; wbAddrA_i = a; wbValA_i = v; operationStatusA_i = s;
   endtask

   task automatic driveB(input logic en, input logic wb, input logic [4:0] a,
                         input logic [15:0] v, input logic [1:0] s);
      enableB_i = en; wbB_i = wb; wbAddrB_i = a; wbValB_i = v; operationStatusB_i = s;
   endtask

   task automatic clearInputs();
      driveA(1'b0, 1'b0, '0, '0, '0);
      driveB(1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic waitDrainBounded(input int maxCycles);
      for (int i = 0; i < maxCycles; i++) begin
         @(negedge clock_i);
         if (expA.size() == 0 && expB.size() == 0 && !wbA_o && !wbB_o) break;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({wbA_o, wbB_o, fullA_o, fullB_o, overflowA_o, overflowB_o, idle_o} !== 7'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b want=0", {wbA_o, wbB_o, fullA_o, fullB_o, overflowA_o, overflowB_o, idle_o});
      end
      #20 reset_i = 1'b1;
      @(negedge clock_i);
      checks++;
      if (idle_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_idle got=%b want=1", idle_o);
      end
   endtask

   task automatic test_single_push();
      @(posedge clock_i); #1;
      driveA(1'b1, 1'b1, 5'd3, 16'h1234, 2'b10);
      expA.push_back({5'd3, 16'h1234, 2'b10});
      @(posedge clock_i); #1;
      clearInputs();
      @(negedge clock_i);
      checks++;
      if (wbA_o !== 1'b0) begin
         failures++;
         $display("FAIL single_no_bypass got=%b want=0", wbA_o);
      end
      @(negedge clock_i);
      checks++;
      if (wbA_o !== 1'b1 || idle_o !== 1'b0) begin
         failures++;
         $display("FAIL single_strobe got=wb%b idle%b want=wb1 idle0", wbA_o, idle_o);
      end
      @(negedge clock_i);
      checks++;
      if (wbA_o !== 1'b0 || idle_o !== 1'b1) begin
         failures++;
         $display("FAIL single_after got=wb%b idle%b want=wb0 idle1", wbA_o, idle_o);
      end
   endtask

   task automatic test_back_to_back();
      logic sawFull;
      sawFull = 1'b0;
      @(posedge clock_i); #1;
      for (int i = 0; i < 5; i++) begin
         driveA(1'b1, 1'b1, 5'(i + 1), 16'h0100 + 16'(i), 2'(i));
         expA.push_back({5'(i + 1), 16'h0100 + 16'(i), 2'(i)});
         @(posedge clock_i); #1;
         if (fullA_o) sawFull = 1'b1;
      end
      clearInputs();
      waitDrainBounded(20);
      checks++;
      if (expA.size() != 0 || overflowA_o !== 1'b0 || sawFull) begin
         failures++;
         $display("FAIL b2b_drain got=left%0d ovf%b full%b want=left0 ovf0 full0", expA.size(), overflowA_o, sawFull);
      end
   endtask

   task automatic test_collision();
      @(posedge clock_i); #1;
      driveA(1'b1, 1'b1, 5'd7, 16'd1, 2'b00);
      driveB(1'b1, 1'b1, 5'd7, 16'd2, 2'b01);
      expA.push_back({5'd7, 16'd1, 2'b00});
      expB.push_back({5'd7, 16'd2, 2'b01});
      @(posedge clock_i); #1;
      clearInputs();
      @(negedge clock_i);
      @(negedge clock_i);
      checks++;
      if (wbA_o !== 1'b1 || wbB_o !== 1'b0) begin
         failures++;
         $display("FAIL collide_first got=A%b B%b want=A1 B0", wbA_o, wbB_o);
      end
      @(negedge clock_i);
      checks++;
      if (wbA_o !== 1'b0 || wbB_o !== 1'b1) begin
         failures++;
         $display("FAIL collide_second got=A%b B%b want=A0 B1", wbA_o, wbB_o);
      end
      @(negedge clock_i);
      checks++;
      if (regs[7] !== 16'd2) begin
         failures++;
         $display("FAIL collide_reg7 got=%0d want=2", regs[7]);
      end
   endtask

   // B is held behind colliding A heads every cycle, so only B fills.
   task automatic test_full_overflow();
      logic [4:0] fullWant;
      fullWant = 5'b11100;
      @(posedge clock_i); #1;
      for (int k = 0; k < 5; k++) begin
         driveA(1'b1, 1'b1, 5'd9, 16'h0A00 + 16'(k), 2'b00);
         driveB(1'b1, 1'b1, 5'd9, 16'h0B00 + 16'(k), 2'b11);
         expA.push_back({5'd9, 16'h0A00 + 16'(k), 2'b00});
         if (k < 4) expB.push_back({5'd9, 16'h0B00 + 16'(k), 2'b11});
         @(posedge clock_i); #1;
         checks++;
         if (fullB_o !== fullWant[k] || overflowB_o !== (k >= 4) || fullA_o !== 1'b0) begin
            failures++;
            $display("FAIL full_step%0d got=fullB%b ovfB%b fullA%b want=fullB%b ovfB%b fullA0",
                     k, fullB_o, overflowB_o, fullA_o, fullWant[k], (k >= 4));
         end
      end
      clearInputs();
      waitDrainBounded(20);
      checks++;
      if (expA.size() != 0 || expB.size() != 0 || overflowB_o !== 1'b1 ||
          overflowA_o !== 1'b0 || fullB_o !== 1'b0) begin
         failures++;
         $display("FAIL full_drain got=leftA%0d leftB%0d ovfB%b ovfA%b fullB%b want=0 0 1 0 0",
                  expA.size(), expB.size(), overflowB_o, overflowA_o, fullB_o);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clock_i); #1;
      for (int k = 0; k < 3; k++) begin
         driveA(1'b1, 1'b1, 5'd10, 16'h0C00 + 16'(k), 2'b01);
         driveB(1'b1, 1'b1, 5'd10, 16'h0D00 + 16'(k), 2'b10);
         expA.push_back({5'd10, 16'h0C00 + 16'(k), 2'b01});
         expB.push_back({5'd10, 16'h0D00 + 16'(k), 2'b10});
         @(posedge clock_i); #1;
      end
      clearInputs();
      #2 reset_i = 1'b0;
      #1;
      checks++;
      if ({wbA_o, wbB_o, wbAddrA_o, wbValA_o, operationStatusA_o, wbAddrB_o, wbValB_o,
           operationStatusB_o, fullA_o, fullB_o, overflowA_o, overflowB_o, idle_o} !== '0) begin
         failures++;
         $display("FAIL async_reset_outputs got=wbA%b wbB%b valA%h valB%h ovfB%b idle%b want=all0",
                  wbA_o, wbB_o, wbValA_o, wbValB_o, overflowB_o, idle_o);
      end
      expA.delete();
      expB.delete();
      @(posedge clock_i);
      @(posedge clock_i);
      #3 reset_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock_i);
         checks++;
         if (wbA_o !== 1'b0 || wbB_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_strobe%0d got=A%b B%b want=A0 B0", k, wbA_o, wbB_o);
         end
      end
      checks++;
      if (idle_o !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_idle got=%b want=1", idle_o);
      end
   endtask

   task automatic test_no_wb();
      @(posedge clock_i); #1;
      driveB(1'b1, 1'b0, 5'd5, 16'hFFFF, 2'b11);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock_i);
         checks++;
         if (wbB_o !== 1'b0 || idle_o !== 1'b1 || fullB_o !== 1'b0) begin
            failures++;
            $display("FAIL no_wb%0d got=wbB%b idle%b fullB%b want=wbB0 idle1 fullB0", k, wbB_o, idle_o, fullB_o);
         end
         if (k == 2) begin
            @(posedge clock_i); #1;
            clearInputs();
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = '0;
      test_reset();
      test_single_push();
      test_back_to_back();
      test_collision();
      test_full_overflow();
      test_async_reset();
      test_no_wb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
